regfile_dump_streamer: RTL



---
 rtl/riscv_dbg_pkg.sv | 32 +++
 rtl/regfile_dump_streamer_if.sv | 34 +++
 rtl/regfile_dump_streamer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/riscv_dbg_pkg.sv
// Shared debug-readback definitions.
// Holds the register index width, the data width, the dump FSM state type,
// a packed stream word record (also meant for a later memory-dump streamer)
// and the range validity helper used when a dump is requested.
package riscv_dbg_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } dump_state_t;

    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic [REG_IDX_W-1:0] index;
        logic                 last;
    } dump_word_t;

    // A range is dumpable when it is ordered and its upper end exists.
    function automatic logic dump_range_valid(
        input logic [REG_IDX_W-1:0] first_idx,
        input logic [REG_IDX_W-1:0] last_idx,
        input int                   num_regs
    );
        return (first_idx <= last_idx) && (int'(last_idx) < num_regs);
    endfunction

endpackage

// File: rtl/regfile_dump_streamer_if.sv
// Valid/ready word stream carrying one dumped register per transfer.
//   valid/ready : handshake, a word moves when both are high on a clock edge
//   data        : register value
//   index       : register index of data
//   last        : marks the final word of the requested range
// master = producer (streamer), slave = consumer.
interface regfile_dump_streamer_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
);

    logic             valid;
    logic             ready;
    logic [XLEN-1:0]  data;
    logic [IDX_W-1:0] index;
    logic             last;

    modport master (
        output valid,
        output data,
        output index,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  index,
        input  last,
        output ready
    );

endinterface

// File: rtl/regfile_dump_streamer.sv
// Register-file dump streamer.
// Walks registers first_reg..last_reg through the regfile debug read port and
// emits each value on a valid/ready stream, accumulating a mod-2^XLEN sum.
// Ports:
//   clock, reset         : single clock, synchronous active-high reset
//   start                : one-cycle dump request, honoured only when idle
//   first_reg, last_reg  : inclusive range, sampled with start
//   dbg_raddr, dbg_rdata : debug read port (combinational read data)
//   out_if               : stream master (valid, ready, data, index, last)
//   busy                 : engine not idle
//   done                 : one-cycle completion pulse
//   checksum             : sum of words sent, valid with done, held afterwards
module regfile_dump_streamer
    import riscv_dbg_pkg::*;
#(
    parameter int XLEN     = riscv_dbg_pkg::XLEN,
    parameter int NUM_REGS = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [REG_IDX_W-1:0]         first_reg,
    input  logic [REG_IDX_W-1:0]         last_reg,
    output logic [REG_IDX_W-1:0]         dbg_raddr,
    input  logic [XLEN-1:0]              dbg_rdata,
    regfile_dump_streamer_if.master      out_if,
    output logic                         busy,
    output logic                         done,
    output logic [XLEN-1:0]              checksum
);

    dump_state_t          state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic [REG_IDX_W-1:0] last_q, last_d;
    logic [XLEN-1:0]      acc_q, acc_d;
    logic [REG_IDX_W-1:0] raddr_q, raddr_d;
    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      data_q, data_d;
    logic [REG_IDX_W-1:0] index_q, index_d;
    logic                 wlast_q, wlast_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [XLEN-1:0]      checksum_q, checksum_d;
    logic                 range_ok_s;
    logic                 handshake_s;
    logic [XLEN-1:0]      acc_sum_s;
    logic [REG_IDX_W-1:0] idx_inc_s;

    assign range_ok_s  = dump_range_valid(first_reg, last_reg, NUM_REGS);
    assign handshake_s = valid_q && out_if.ready;
    assign acc_sum_s   = acc_q + data_q;
    assign idx_inc_s   = idx_q + {{(REG_IDX_W-1){1'b0}}, 1'b1};

    // Next-state and registered-output computation for the dump FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        acc_d      = acc_q;
        raddr_d    = raddr_q;
        valid_d    = valid_q;
        data_d     = data_q;
        index_d    = index_q;
        wlast_d    = wlast_q;
        done_d     = 1'b0;
        checksum_d = checksum_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (range_ok_s) begin
                        idx_d   = first_reg;
                        last_d  = last_reg;
                        acc_d   = {XLEN{1'b0}};
                        // The read address is set up on entry so the regfile
                        // answers during READ without a combinational path.
                        raddr_d = first_reg;
                        state_d = READ;
                    end else begin
                        acc_d      = {XLEN{1'b0}};
                        checksum_d = {XLEN{1'b0}};
                        done_d     = 1'b1;
                        state_d    = FINISH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                // x0 is architecturally zero whatever the port returns.
                if (idx_q == {REG_IDX_W{1'b0}}) begin
                    data_d = {XLEN{1'b0}};
                end else begin
                    data_d = dbg_rdata;
                end
                index_d = idx_q;
                wlast_d = (idx_q == last_q);
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (handshake_s) begin
                    acc_d   = acc_sum_s;
                    valid_d = 1'b0;
                    if (wlast_q) begin
                        // done and checksum become visible during FINISH.
                        checksum_d = acc_sum_s;
                        done_d     = 1'b1;
                        state_d    = FINISH;
                    end else begin
                        idx_d   = idx_inc_s;
                        raddr_d = idx_inc_s;
                        state_d = READ;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= {REG_IDX_W{1'b0}};
            last_q     <= {REG_IDX_W{1'b0}};
            acc_q      <= {XLEN{1'b0}};
            raddr_q    <= {REG_IDX_W{1'b0}};
            valid_q    <= 1'b0;
            data_q     <= {XLEN{1'b0}};
            index_q    <= {REG_IDX_W{1'b0}};
            wlast_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            checksum_q <= {XLEN{1'b0}};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            acc_q      <= acc_d;
            raddr_q    <= raddr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            index_q    <= index_d;
            wlast_q    <= wlast_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            checksum_q <= checksum_d;
        end
    end

    assign dbg_raddr    = raddr_q;
    assign out_if.valid = valid_q;
    assign out_if.data  = data_q;
    assign out_if.index = index_q;
    assign out_if.last  = wlast_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign checksum     = checksum_q;

endmodule
